mem_stage: RTL and testbench

Memory stage of the 5-stage ARM pipeline, directly downstream of the execute stage. Consumes the EXE/MEM register outputs: ALU result as byte address, store data, destination register and control bits. Performs data-memory loads and stores against an internal word-organised RAM with a fixed multi-cycle access latency, and stalls the pipeline through `ready` while an access is in flight. Registers its results into the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage.sv | 112 +++++++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM pipeline: multi-cycle loads/stores against a
// word-organised data RAM, stalling upstream via `ready`, feeding the MEM/WB register.
module mem_stage #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  dest_in,
  output logic        ready,
  output logic        wb_en,
  output logic        mem_read_en,
  output logic [31:0] alu_res,
  output logic [31:0] mem_data,
  output logic [3:0]  dest
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nxt;
  logic [31:0]   ram [DEPTH];
  logic          req;
  logic          in_range;
  logic          ram_we;
  logic [31:0]   offset;
  logic [31:0]   word_idx;
  logic [31:0]   rd_data;
  logic [AW-1:0] ram_addr;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign req      = mem_read_en_in | mem_write_en_in;
  assign offset   = alu_res_in - BASE_W;
  assign word_idx = offset >> 2;
  assign in_range = (word_idx < DEPTH_W) && (alu_res_in[1:0] == 2'b00);
  assign ram_addr = word_idx[AW-1:0];
  assign rd_data  = in_range ? ram[ram_addr] : 32'd0;

  assign ready  = (state == ST_DONE) || ((state == ST_IDLE) && !req);
  assign ram_we = (state == ST_DONE) && mem_write_en_in && in_range && !rst;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          cnt_nxt   = LAT_M1;
          state_nxt = (LATENCY == 1) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM/WB register: capture when ready, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en       <= 1'b0;
      mem_read_en <= 1'b0;
      alu_res     <= 32'd0;
      mem_data    <= 32'd0;
      dest        <= 4'd0;
    end else if (ready) begin
      wb_en       <= wb_en_in;
      mem_read_en <= mem_read_en_in;
      alu_res     <= alu_res_in;
      dest        <= dest_in;
      if (mem_read_en_in) mem_data <= rd_data;
    end else begin
      wb_en       <= 1'b0;
      mem_read_en <= 1'b0;
    end
  end

  // Data RAM is not cleared by reset; a store commits only at its DONE edge.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= val_Rm_in;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-cycle behavioural model checked on every negedge,
// plus directed literal expectations; a second instance runs with LATENCY=1.
module tb_mem_stage;

  localparam int LAT   = 3;
  localparam int DEPTH = 64;
  localparam int BASE  = 1024;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;
  logic        ready, wb_en, mem_read_en;
  logic [31:0] alu_res, mem_data;
  logic [3:0]  dest;

  logic        rst1;
  logic        b_wb_en_in, b_mem_read_en_in, b_mem_write_en_in;
  logic [31:0] b_alu_res_in, b_val_Rm_in;
  logic [3:0]  b_dest_in;
  logic        ready1, wb_en1, mem_read_en1;
  logic [31:0] alu_res1, mem_data1;
  logic [3:0]  dest1;

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .ready(ready), .wb_en(wb_en), .mem_read_en(mem_read_en),
    .alu_res(alu_res), .mem_data(mem_data), .dest(dest)
  );

  mem_stage #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .wb_en_in(b_wb_en_in), .mem_read_en_in(b_mem_read_en_in), .mem_write_en_in(b_mem_write_en_in),
    .alu_res_in(b_alu_res_in), .val_Rm_in(b_val_Rm_in), .dest_in(b_dest_in),
    .ready(ready1), .wb_en(wb_en1), .mem_read_en(mem_read_en1),
    .alu_res(alu_res1), .mem_data(mem_data1), .dest(dest1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int s0;
  logic chk_en = 1'b0;

  // model of the expected outputs and RAM contents
  logic        m_ready;
  logic        m_wb_en, m_mem_read_en;
  logic [31:0] m_alu_res, m_mem_data;
  logic [3:0]  m_dest;
  logic [31:0] m_ram [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, updating the model by the capture/bubble rules.
  task automatic step();
    bit inr;
    int idx;
    @(posedge clk);
    inr = (alu_res_in >= 32'(BASE)) && (alu_res_in < 32'(BASE + 4 * DEPTH)) &&
          (alu_res_in[1:0] == 2'b00);
    idx = inr ? int'((alu_res_in - 32'(BASE)) / 4) : 0;
    if (rst) begin
      m_wb_en = 0; m_mem_read_en = 0; m_alu_res = 0; m_mem_data = 0; m_dest = 0;
    end else if (m_ready) begin
      if (mem_write_en_in && inr) m_ram[idx] = val_Rm_in;
      if (mem_read_en_in) m_mem_data = inr ? m_ram[idx] : 32'd0;
      m_wb_en       = wb_en_in;
      m_mem_read_en = mem_read_en_in;
      m_alu_res     = alu_res_in;
      m_dest        = dest_in;
    end else begin
      m_wb_en       = 0;
      m_mem_read_en = 0;
    end
    #1;
  endtask

  // driver tasks
  task automatic set_in(input logic we, input logic re, input logic wb,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] d);
    mem_write_en_in = we; mem_read_en_in = re; wb_en_in = wb;
    alu_res_in = addr; val_Rm_in = data; dest_in = d;
  endtask

  task automatic alu_op(input logic wb, input logic [31:0] res, input logic [3:0] d);
    set_in(1'b0, 1'b0, wb, res, 32'h0, d);
    m_ready = 1'b1;
    step();
  endtask

  task automatic mem_op(input logic we, input logic re, input logic wb,
                        input logic [31:0] addr, input logic [31:0] data, input logic [3:0] d);
    set_in(we, re, wb, addr, data, d);
    for (int k = 0; k <= LAT; k++) begin
      m_ready = (k == LAT);
      step();
    end
  endtask

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, ready}, {31'b0, m_ready});
      check("wb_en", {31'b0, wb_en}, {31'b0, m_wb_en});
      check("mem_read_en", {31'b0, mem_read_en}, {31'b0, m_mem_read_en});
      check("alu_res", alu_res, m_alu_res);
      check("mem_data", mem_data, m_mem_data);
      check("dest", {28'b0, dest}, {28'b0, m_dest});
      if (ready !== 1'b1) stall_cnt++;
    end
  end

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    b_wb_en_in = 0; b_mem_read_en_in = 0; b_mem_write_en_in = 0;
    b_alu_res_in = 0; b_val_Rm_in = 0; b_dest_in = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst1 = 1'b0;
    m_wb_en = 0; m_mem_read_en = 0; m_alu_res = 0; m_mem_data = 0; m_dest = 0;
    m_ready = 1'b1;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_wb_en", {31'b0, wb_en}, 32'd0);
    check("rst_alu_res", alu_res, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_dest", {28'b0, dest}, 32'd0);
    chk_en = 1'b1;

    // plain ALU op: one-cycle pass-through, no stall
    s0 = stall_cnt;
    alu_op(1'b1, 32'h55, 4'd3);
    check("alu_res_55", alu_res, 32'h55);
    check("alu_dest_3", {28'b0, dest}, 32'd3);
    check("alu_wb_en", {31'b0, wb_en}, 32'd1);
    check("alu_no_stall", 32'(stall_cnt - s0), 32'd0);

    // store to 1028, stalled exactly LATENCY cycles with bubbles
    s0 = stall_cnt;
    mem_op(1'b1, 1'b0, 1'b0, 32'd1028, 32'hDEADBEEF, 4'd0);
    check("store_stall", 32'(stall_cnt - s0), 32'd3);
    mem_op(1'b1, 1'b0, 1'b0, 32'd1024, 32'h01010101, 4'd0);
    alu_op(1'b1, 32'h1234, 4'd5);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 4'd2);
    check("load_1028", mem_data, 32'hDEADBEEF);
    check("load_rd_en", {31'b0, mem_read_en}, 32'd1);
    check("load_dest", {28'b0, dest}, 32'd2);

    // back-to-back store then load to the same word
    s0 = stall_cnt;
    mem_op(1'b1, 1'b0, 1'b0, 32'd1032, 32'hA5A5A5A5, 4'd0);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0, 4'd4);
    check("b2b_stall", 32'(stall_cnt - s0), 32'd6);
    check("b2b_load", mem_data, 32'hA5A5A5A5);

    // out-of-range and misaligned accesses
    s0 = stall_cnt;
    mem_op(1'b0, 1'b1, 1'b1, 32'(BASE + 4 * DEPTH), 32'h0, 4'd6);
    check("oor_load", mem_data, 32'd0);
    check("oor_stall", 32'(stall_cnt - s0), 32'd3);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 4'd6);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1025, 32'h0, 4'd7);
    check("misalign_load", mem_data, 32'd0);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1020, 32'h0, 4'd7);
    check("below_base_load", mem_data, 32'd0);
    mem_op(1'b1, 1'b0, 1'b0, 32'd1025, 32'hFFFFFFFF, 4'd0);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1024, 32'h0, 4'd1);
    check("word0_kept", mem_data, 32'h01010101);
    mem_op(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0, 4'd1);
    check("word1_kept", mem_data, 32'hDEADBEEF);

    // non-load keeps mem_data
    alu_op(1'b1, 32'hCAFE, 4'd9);
    check("nonload_hold", mem_data, 32'hDEADBEEF);

    // reset in the second BUSY cycle of a store
    mem_op(1'b1, 1'b0, 1'b0, 32'd1036, 32'h11112222, 4'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'd1036, 32'h99999999, 4'd8);
    m_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m_ready = 1'b1;
    check("midrst_alu_res", alu_res, 32'd0);
    check("midrst_mem_data", mem_data, 32'd0);
    check("midrst_wb_en", {31'b0, wb_en}, 32'd0);
    step();
    mem_op(1'b0, 1'b1, 1'b1, 32'd1036, 32'h0, 4'd10);
    check("midrst_old_val", mem_data, 32'h11112222);
    alu_op(1'b0, 32'h0, 4'd0);
    chk_en = 1'b0;

    // LATENCY=1 instance
    b_mem_write_en_in = 1; b_alu_res_in = 32'd1024; b_val_Rm_in = 32'hCAFEF00D;
    @(negedge clk);
    check("l1_store_t0", {31'b0, ready1}, 32'd0);
    @(negedge clk);
    check("l1_store_t1", {31'b0, ready1}, 32'd1);
    @(posedge clk); #1;
    b_mem_write_en_in = 0; b_mem_read_en_in = 1; b_wb_en_in = 1; b_dest_in = 4'd7;
    @(negedge clk);
    check("l1_load_t0", {31'b0, ready1}, 32'd0);
    @(negedge clk);
    check("l1_load_t1", {31'b0, ready1}, 32'd1);
    @(posedge clk); #1;
    b_mem_read_en_in = 0; b_wb_en_in = 0; b_dest_in = 0; b_alu_res_in = 0;
    check("l1_mem_data", mem_data1, 32'hCAFEF00D);
    check("l1_rd_en", {31'b0, mem_read_en1}, 32'd1);
    check("l1_dest", {28'b0, dest1}, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
